shifter_arbiter_2req: RTL and testbench
=======================================

Name: shifter_arbiter_2req

Overview:
Two-requester round-robin arbiter that shares one combinational 16-bit left barrel shifter (barrelShifterLeft, instantiated inside this block).
- Each requester presents an operand and a 4-bit shift magnitude over a valid/ready handshake.
- The winning operand is shifted, and the result is registered into a single-entry output buffer with its own valid/ready handshake.
- Per-requester saturating grant counters support performance monitoring.

Parameters:
CNT_W, 8, width of each per-requester grant counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
req0_valid  input  1  requester 0 has a request.
req0_data  input  16  requester 0 operand.
req0_mag  input  4  requester 0 left-shift magnitude, 0..15.
req0_ready  output  1  requester 0 request accepted this cycle.
req1_valid  input  1  requester 1 has a request.
req1_data  input  16  requester 1 operand.
req1_mag  input  4  requester 1 left-shift magnitude, 0..15.
req1_ready  output  1  requester 1 request accepted this cycle.
rsp_valid  output  1  output buffer holds a result.
rsp_data  output  16  shifted result, zero-filled from bit 0.
rsp_id  output  1  index of the requester that produced rsp_data.
rsp_ready  input  1  consumer accepts the result this cycle.
gnt_cnt0  output  CNT_W  number of accepted requests from requester 0, saturating.
gnt_cnt1  output  CNT_W  number of accepted requests from requester 1, saturating.

Behaviour:
- Reset values (synchronous, active-high): rsp_valid=0, rsp_data=0, rsp_id=0, gnt_cnt0=0, gnt_cnt1=0, last_grant=1, so requester 0 wins the first tie.
- Output buffer states:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
- can_accept = ~rsp_valid | rsp_ready (combinational).
- Grant selection (combinational):
  - Only one valid: that requester.
  - Both valid: the requester that is not last_grant.
  - None valid: no grant.
- reqN_ready = can_accept & (grant==N), combinational. At most one ready is high per cycle. A ready may be high only when the matching valid is high.
- Accept event = reqN_valid & reqN_ready. On the next edge:
  - rsp_data <= reqN_data << reqN_mag, computed through the shifter instance.
  - rsp_id <= N.
  - rsp_valid <= 1.
  - last_grant <= N.
  - gnt_cntN increments, holding at all-ones once saturated.
- Latency: result is visible one cycle after acceptance.
- Throughput: one result per cycle when rsp_ready is held high.
- Consume with no accept (rsp_valid & rsp_ready, no request accepted): rsp_valid <= 0. rsp_data and rsp_id hold their last values.
- Simultaneous consume and accept: the new result replaces the old in the same edge, so there is no bubble. rsp_valid stays 1.
- FULL with rsp_ready=0:
  - Both readys are 0.
  - rsp_data and rsp_id are held stable.
  - last_grant is unchanged.
- Requesters must hold valid, data and mag stable until accepted. The block does not latch unaccepted requests.
- last_grant changes only on an accept. Arbitration priority therefore does not rotate while a request is blocked.
- Magnitude 0 passes the operand unchanged. Magnitude 15 leaves only bit 0 of the operand, placed at bit 15.
- Reset asserted mid-operation:
  - Any buffered result is dropped and rsp_valid=0 on the next edge.
  - Both readys are 0 during reset.
  - Counters and last_grant return to their reset values.
- Fairness: with both requesters continuously valid and rsp_ready=1, grants alternate 0,1,0,1 from reset.

Test Plan:
- Single request: reset, then req0 with data 0x0001, mag 4, rsp_ready=1 -> req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_data=0x0010, rsp_id=0, gnt_cnt0=1.
- Shift boundaries: req1 with 0xFFFF mag 15 -> rsp_data=0x8000. Then 0xA5A5 mag 0 -> 0xA5A5. Then 0x1234 mag 8 -> 0x3400. All with rsp_id=1.
- Round-robin: both valid continuously for 6 cycles, req0 data 0x0003 mag 1, req1 data 0x0003 mag 2, rsp_ready=1 -> rsp_id sequence 0,1,0,1,0,1; rsp_data alternates 0x0006/0x000C; gnt_cnt0=gnt_cnt1=3.
- Backpressure: buffer FULL and rsp_ready=0 for 3 cycles with both requests valid -> both readys 0, rsp_data stable. Raise rsp_ready -> the next result appears with no bubble, and the grant goes to the requester not last served.
- Reset mid-operation: rsp_valid=1 holding 0x00F0, assert reset for 1 cycle -> next cycle rsp_valid=0, counters=0, and the first tie afterwards goes to requester 0.
- Saturation: CNT_W=2, issue 5 req0 accepts -> gnt_cnt0 reads 1,2,3,3,3.

Source files
------------

// File: rtl/shifter_arbiter_2req.sv
// shifter_arbiter_2req: two-requester round-robin arbiter sharing a 16-bit left barrel shifter
module barrelShifterLeft (
  input  logic [15:0] data,
  input  logic [3:0]  mag,
  output logic [15:0] result
);
  logic [15:0] s [5];
  assign s[0] = data;
  for (genvar g = 0; g < 4; g++) begin : g_stage
    assign s[g+1] = mag[g] ? s[g] << (1 << g) : s[g];
  end
  assign result = s[4];
endmodule

module shifter_arbiter_2req #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [15:0]      req0_data,
  input  logic [3:0]       req0_mag,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [15:0]      req1_data,
  input  logic [3:0]       req1_mag,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic [15:0]      rsp_data,
  output logic             rsp_id,
  input  logic             rsp_ready,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);
  logic        last_grant;
  logic        can_accept;
  logic        grant;
  logic        accept;
  logic [15:0] shifted;
  always_comb begin
    can_accept = ~reset & (~rsp_valid | rsp_ready);
    grant      = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    req0_ready = can_accept & req0_valid & ~grant;
    req1_ready = can_accept & req1_valid & grant;
    accept     = req0_ready | req1_ready;
  end
  barrelShifterLeft u_shift (
    .data   (grant ? req1_data : req0_data),
    .mag    (grant ? req1_mag : req0_mag),
    .result (shifted)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
      gnt_cnt0   <= '0;
      gnt_cnt1   <= '0;
    end else begin
      if (accept) begin
        rsp_valid  <= 1'b1;
        rsp_data   <= shifted;
        rsp_id     <= grant;
        last_grant <= grant;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (req0_ready) gnt_cnt0 <= gnt_cnt0 + CNT_W'(~&gnt_cnt0);
      if (req1_ready) gnt_cnt1 <= gnt_cnt1 + CNT_W'(~&gnt_cnt1);
    end
  end
endmodule

// File: tb/tb_shifter_arbiter_2req.sv
// tb_shifter_arbiter_2req: randomized and directed checks against a behavioural model
module tb_shifter_arbiter_2req;
  logic        clk = 0;
  logic        reset = 1;
  logic        req0_valid = 0, req1_valid = 0, rsp_ready = 0;
  logic [15:0] req0_data = 0, req1_data = 0;
  logic [3:0]  req0_mag = 0, req1_mag = 0;
  logic        r0, r1, rv, ri, s_r0, s_r1, s_rv, s_ri;
  logic [15:0] rd, s_rd;
  logic [7:0]  c0, c1;
  logic [1:0]  s_c0, s_c1;
  int checks = 0, failures = 0;
  bit run = 0;
  bit    m_valid = 0, m_id = 0, m_last = 1;
  int    m_data = 0, m_c0 = 0, m_c1 = 0;
  always #5 clk = ~clk;
  shifter_arbiter_2req #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_mag(req0_mag), .req0_ready(r0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_mag(req1_mag), .req1_ready(r1),
    .rsp_valid(rv), .rsp_data(rd), .rsp_id(ri), .rsp_ready(rsp_ready),
    .gnt_cnt0(c0), .gnt_cnt1(c1)
  );
  shifter_arbiter_2req #(.CNT_W(2)) dut_s (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_mag(req0_mag), .req0_ready(s_r0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_mag(req1_mag), .req1_ready(s_r1),
    .rsp_valid(s_rv), .rsp_data(s_rd), .rsp_id(s_ri), .rsp_ready(rsp_ready),
    .gnt_cnt0(s_c0), .gnt_cnt1(s_c1)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic int shl(input int d, input int m);
    longint p;
    p = longint'(d) * (longint'(1) << m);
    return int'(p % 65536);
  endfunction
  function automatic int sat(input int c, input int mx);
    return c > mx ? mx : c;
  endfunction
  always @(negedge clk) begin
    int w;
    w = -1;
    if (!reset && (!m_valid || rsp_ready))
      w = (req0_valid && req1_valid) ? 1 - int'(m_last) : req0_valid ? 0 : req1_valid ? 1 : -1;
    if (run) begin
      chk("req0_ready", r0, w == 0);
      chk("req1_ready", r1, w == 1);
      chk("rsp_valid", rv, m_valid);
      chk("rsp_data", rd, m_data);
      chk("rsp_id", ri, m_id);
      chk("gnt_cnt0", c0, sat(m_c0, 255));
      chk("gnt_cnt1", c1, sat(m_c1, 255));
      chk("s_req0_ready", s_r0, w == 0);
      chk("s_req1_ready", s_r1, w == 1);
      chk("s_rsp_valid", s_rv, m_valid);
      chk("s_rsp_data", s_rd, m_data);
      chk("s_rsp_id", s_ri, m_id);
      chk("s_gnt_cnt0", s_c0, sat(m_c0, 3));
      chk("s_gnt_cnt1", s_c1, sat(m_c1, 3));
    end
    if (reset) begin
      m_valid = 0; m_data = 0; m_id = 0; m_last = 1; m_c0 = 0; m_c1 = 0;
    end else if (w >= 0) begin
      m_data  = w == 0 ? shl(req0_data, req0_mag) : shl(req1_data, req1_mag);
      m_valid = 1; m_id = w[0]; m_last = w[0];
      if (w == 0) m_c0++; else m_c1++;
    end else if (rsp_ready) m_valid = 0;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [15:0] bd [3];
    logic [3:0]  bm [3];
    logic [15:0] be [3];
    logic [1:0]  se [5];
    bit a0, a1;
    bd = '{16'hFFFF, 16'hA5A5, 16'h1234};
    bm = '{4'd15, 4'd0, 4'd8};
    be = '{16'h8000, 16'hA5A5, 16'h3400};
    se = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    step();
    run = 1;
    step();
    reset = 0;
    chk("lit_reset_valid", rv, 0);
    chk("lit_reset_cnt0", c0, 0);
    req0_valid = 1; req0_data = 16'h0001; req0_mag = 4; rsp_ready = 1;
    #1 chk("lit_single_ready", r0, 1);
    step();
    req0_valid = 0;
    chk("lit_single_valid", rv, 1);
    chk("lit_single_data", rd, 16'h0010);
    chk("lit_single_id", ri, 0);
    chk("lit_single_cnt0", c0, 1);
    for (int i = 0; i < 3; i++) begin
      req1_valid = 1; req1_data = bd[i]; req1_mag = bm[i];
      step();
      chk("lit_bound_data", rd, be[i]);
      chk("lit_bound_id", ri, 1);
    end
    req1_valid = 0;
    reset = 1;
    step();
    reset = 0;
    req0_valid = 1; req0_data = 3; req0_mag = 1;
    req1_valid = 1; req1_data = 3; req1_mag = 2;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("lit_rr_id", ri, i % 2);
      chk("lit_rr_data", rd, i % 2 ? 16'h000C : 16'h0006);
    end
    rsp_ready = 0;
    chk("lit_rr_cnt0", c0, 3);
    chk("lit_rr_cnt1", c1, 3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lit_bp_ready0", r0, 0);
      chk("lit_bp_ready1", r1, 0);
      chk("lit_bp_data", rd, 16'h000C);
    end
    rsp_ready = 1;
    #1 chk("lit_bp_release_ready0", r0, 1);
    step();
    chk("lit_bp_id", ri, 0);
    chk("lit_bp_data2", rd, 16'h0006);
    req1_valid = 0; req0_data = 16'h000F; req0_mag = 4;
    step();
    req0_valid = 0; rsp_ready = 0;
    chk("lit_mid_data", rd, 16'h00F0);
    reset = 1; req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    #1 chk("lit_rst_ready0", r0, 0);
    step();
    reset = 0;
    chk("lit_rst_valid", rv, 0);
    chk("lit_rst_cnt0", c0, 0);
    chk("lit_rst_cnt1", c1, 0);
    #1 chk("lit_rst_tie", r0, 1);
    step();
    chk("lit_rst_tie_id", ri, 0);
    req1_valid = 0;
    reset = 1;
    step();
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("lit_sat_cnt0", s_c0, se[i]);
    end
    req0_valid = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      a0 = req0_valid && r0;
      a1 = req1_valid && r1;
      @(posedge clk);
      #1;
      if (!req0_valid || a0 || reset) begin
        req0_valid = ($urandom % 4) != 0; req0_data = 16'($urandom); req0_mag = 4'($urandom);
      end
      if (!req1_valid || a1 || reset) begin
        req1_valid = ($urandom % 4) != 0; req1_data = 16'($urandom); req1_mag = 4'($urandom);
      end
      rsp_ready = ($urandom % 3) != 0;
      reset = ($urandom % 97) == 0;
    end
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
